// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader
//   Master-side controller for an s25fl128s-style QSPI flash. On start it
//   optionally sets CR1.QUAD (WREN, WRR, RDSR1 poll until WIP clears), then
//   issues Quad Output Read (0x6B) with a 24-bit address and dummy cycles, and
//   streams 32-bit little-endian words to a valid/ready consumer.
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   start, addr,len : 1-cycle request pulse (IDLE only), byte address, word count
//   busy, done      : transfer in progress / 1-cycle completion pulse
//   rd_data,rd_valid,rd_ready : word output handshake (byte 0 in [7:0])
//   sclk, cs, io    : flash pins (SPI mode 0, cs active low, io[3:0] bidirectional)
module qspi_flash_reader #(
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_CYC = 8,
  parameter int SET_QUAD    = 1,
  parameter int DUMMY_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        sclk,
  output logic        cs,
  inout  wire  [3:0]  io
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WRR, S_POLL_CMD, S_POLL_RD, S_RCMD,
    S_RADDR, S_DUMMY, S_DATA, S_HOLD, S_GAP, S_DONE
  } state_e;

  state_e            state_q, state_d;
  state_e            after_q, after_d;    // command to launch when the cs gap ends
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       cnt_q, cnt_d;        // sclk cycles left in phase, or gap cycles
  logic [23:0]       sh_q, sh_d;          // serial output shifter, bit 23 on io[0]
  logic              oe_q, oe_d;          // drive io[0], io[3:2]
  logic [7:0]        sr_q, sr_d;          // SR1 as shifted in from io[1]
  logic [31:0]       word_q, word_d;      // nibbles in arrival order, byte 0 on top
  logic [23:0]       addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [31:0]       rd_data_q, rd_data_d;

  logic              shifting, tick, rise, fall, last_bit, load;
  state_e            load_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      after_q    <= S_IDLE;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      oe_q       <= 1'b0;
      sr_q       <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      after_q    <= after_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      oe_q       <= oe_d;
      sr_q       <= sr_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    after_d    = after_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    oe_d       = oe_q;
    sr_d       = sr_q;
    word_d     = word_q;
    addr_d     = addr_q;
    len_d      = len_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    load       = 1'b0;
    load_st    = S_IDLE;

    // The divider runs only while cs is low and a clocked phase is active;
    // S_HOLD is excluded, which freezes sclk low while a word waits.
    shifting = !cs_q && (state_q inside {S_WREN, S_WRR, S_POLL_CMD, S_POLL_RD,
                                         S_RCMD, S_RADDR, S_DUMMY, S_DATA});
    tick     = shifting && (div_q == DIV_MAX);
    rise     = tick && !sclk_q;
    fall     = tick && sclk_q;
    last_bit = fall && (cnt_q == 16'd1);

    if (shifting) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // Output bits advance on the falling edge so the flash sees stable data
    // at the next rising edge.
    if (fall && !last_bit) begin
      cnt_d = cnt_q - 16'd1;
      sh_d  = {sh_q[22:0], 1'b0};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = addr;
          len_d  = len;
          busy_d = 1'b1;
          if (len == 16'd0) begin
            state_d = S_DONE;
          end else begin
            load    = 1'b1;
            load_st = (SET_QUAD != 0) ? S_WREN : S_RCMD;
          end
        end
      end
      S_WREN, S_WRR: begin
        if (last_bit) begin
          cs_d    = 1'b1;
          oe_d    = 1'b0;
          state_d = S_GAP;
          after_d = (state_q == S_WREN) ? S_WRR : S_POLL_CMD;
          cnt_d   = 16'(CS_HIGH_CYC);
        end
      end
      S_POLL_CMD: begin
        if (last_bit) begin
          load    = 1'b1;
          load_st = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        if (rise) sr_d = {sr_q[6:0], io[1]};
        // sr_q already holds the whole byte here: its last bit came on the
        // preceding rising edge.
        if (last_bit) begin
          if (!sr_q[0]) begin
            cs_d    = 1'b1;
            oe_d    = 1'b0;
            state_d = S_GAP;
            after_d = S_RCMD;
            cnt_d   = 16'(CS_HIGH_CYC);
          end else begin
            load    = 1'b1;
            load_st = S_POLL_RD;
          end
        end
      end
      S_RCMD: begin
        if (last_bit) begin
          load    = 1'b1;
          load_st = S_RADDR;
        end
      end
      S_RADDR: begin
        if (last_bit) begin
          load    = 1'b1;
          load_st = (DUMMY_CYC == 0) ? S_DATA : S_DUMMY;
        end
      end
      S_DUMMY: begin
        if (last_bit) begin
          load    = 1'b1;
          load_st = S_DATA;
        end
      end
      S_DATA: begin
        if (rise) word_d = {word_q[27:0], io};
        if (last_bit) begin
          state_d    = S_HOLD;
          rd_valid_d = 1'b1;
          rd_data_d  = {word_q[7:0], word_q[15:8], word_q[23:16], word_q[31:24]};
        end
      end
      S_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          len_d      = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = S_DONE;
            cs_d    = 1'b1;
          end else begin
            load    = 1'b1;
            load_st = S_DATA;
          end
        end
      end
      S_GAP: begin
        if (cnt_q <= 16'd1) begin
          load    = 1'b1;
          load_st = after_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        sclk_d  = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Start of a new clocked phase: cs low (or kept low), sclk low, divider
    // restarted, first output bit presented before the first rising edge.
    if (load) begin
      state_d = load_st;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      div_d   = '0;
      oe_d    = 1'b1;
      case (load_st)
        S_WREN:     begin sh_d = {8'h06, 16'h0000}; cnt_d = 16'd8;  end
        S_WRR:      begin sh_d = {8'h01, 8'h00, 8'h02}; cnt_d = 16'd24; end
        S_POLL_CMD: begin sh_d = {8'h05, 16'h0000}; cnt_d = 16'd8;  end
        S_POLL_RD:  begin sh_d = '0;                cnt_d = 16'd8;  end
        S_RCMD:     begin sh_d = {8'h6B, 16'h0000}; cnt_d = 16'd8;  end
        S_RADDR:    begin sh_d = addr_q;            cnt_d = 16'd24; end
        S_DUMMY:    begin oe_d = 1'b0; cnt_d = 16'(DUMMY_CYC); end
        S_DATA:     begin oe_d = 1'b0; cnt_d = 16'd8; end
        default:    begin oe_d = 1'b0; end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign sclk     = sclk_q;
  assign cs       = cs_q;

  // io[1] is never driven by the controller; it carries SR1 from the flash.
  assign io[0] = oe_q ? sh_q[23] : 1'bz;
  assign io[2] = oe_q ? 1'b1 : 1'bz;
  assign io[3] = oe_q ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Testbench for qspi_flash_reader: behavioural flash model on the pins,
// scoreboard of expected words, independent monitor process.
module tb_qspi_flash_reader;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        rd_ready = 1'b0;
  wire         busy, done, rd_valid, sclk, cs;
  wire  [31:0] rd_data;
  wire  [3:0]  io;

  always #5 clk = ~clk;

  qspi_flash_reader #(.CLK_DIV(2), .CS_HIGH_CYC(8), .SET_QUAD(1), .DUMMY_CYC(D)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .sclk(sclk), .cs(cs), .io(io)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0]  mem [0:255];
  logic [3:0]  fl_oe = '0;
  logic [3:0]  fl_drv = '0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  int          rcnt = 0, wip_cnt = 0, cs_falls = 0, fj, fk, fidx;
  logic [7:0]  op = '0, cr1 = '0, fb;
  logic [31:0] fsh = '0;
  logic [23:0] faddr = '0;
  logic        wel = 1'b0;
  logic [7:0]  exp_cmd [$];

  for (genvar gi = 0; gi < 4; gi++) begin : g_fl
    assign io[gi] = fl_oe[gi] ? fl_drv[gi] : 1'bz;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (prev_cs && !cs) begin
        rcnt = 0; op = '0; cs_falls++;
      end
      if (!cs && sclk && !prev_sclk) begin
        fsh = {fsh[30:0], io[0]};
        rcnt++;
        if (rcnt % 8 == 0 && (rcnt == 8 || (op == 8'h01 && rcnt <= 24) ||
                              (op == 8'h6B && rcnt <= 32))) begin
          if (exp_cmd.size() == 0) begin
            checks++; failures++;
            $display("FAIL cmd_byte actual=%h required=none", fsh[7:0]);
          end else begin
            chk("cmd_byte", {24'h0, fsh[7:0]}, {24'h0, exp_cmd.pop_front()});
          end
          if (rcnt == 8) begin
            op = fsh[7:0];
            if (op == 8'h06) wel = 1'b1;
            if (op == 8'h6B) chk("quad_before_read", {31'h0, cr1[1]}, 32'h1);
          end
        end
        if (op == 8'h6B && rcnt == 32) faddr = fsh[23:0];
      end
      if (!cs && !sclk && prev_sclk) begin
        if (op == 8'h05 && rcnt >= 8) begin
          fj = rcnt - 8;
          if (fj > 0 && fj % 8 == 0 && wip_cnt > 0) wip_cnt--;
          fl_oe  = 4'b0010;
          fl_drv = {2'b00, (fj % 8 == 7) && (wip_cnt > 0), 1'b0};
        end
        if (op == 8'h6B && rcnt >= 32 + D) begin
          fk   = rcnt - 32 - D;
          fidx = (int'(faddr) + fk / 2) % 256;
          fb   = mem[fidx];
          fl_oe  = 4'hF;
          fl_drv = (fk % 2 == 0) ? fb[7:4] : fb[3:0];
        end
      end
      if (!prev_cs && cs) begin
        fl_oe = '0;
        if (op == 8'h01 && rcnt == 24 && wel) begin
          cr1 = fsh[7:0]; wip_cnt = 2; wel = 1'b0;
        end
      end
      prev_cs = cs;
      prev_sclk = sclk;
    end
  end

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = mem[(int'(a) + j) % 256];
    return w;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] sb_q [$];
  int          done_cnt = 0;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_d = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (prev_v && !prev_r && !prev_rst && !rst) begin
        chk("hold_valid", {31'h0, rd_valid}, 32'h1);
        chk("hold_data", rd_data, prev_d);
        chk("hold_sclk", {31'h0, sclk}, 32'h0);
        chk("hold_cs", {31'h0, cs}, 32'h0);
      end
      if (rd_valid && rd_ready && !rst) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL word actual=%h required=none", rd_data);
        end else begin
          chk("word", rd_data, sb_q.pop_front());
        end
      end
      prev_v = rd_valid; prev_r = rd_ready; prev_d = rd_data; prev_rst = rst;
    end
  end

  // ready driver for random back-pressure mode
  int ready_mode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) rd_ready = ($urandom % 4) != 0;
    end
  end

  task automatic push_expect(input logic [23:0] a, input logic [15:0] n);
    if (n != 0) begin
      exp_cmd.push_back(8'h06);
      exp_cmd.push_back(8'h01); exp_cmd.push_back(8'h00); exp_cmd.push_back(8'h02);
      exp_cmd.push_back(8'h05);
      exp_cmd.push_back(8'h6B);
      exp_cmd.push_back(a[23:16]); exp_cmd.push_back(a[15:8]); exp_cmd.push_back(a[7:0]);
      for (int i = 0; i < int'(n); i++) sb_q.push_back(exp_word(a + 24'(4 * i)));
    end
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; addr = a; len = n;
    @(posedge clk); #1;
    start = 1'b0; addr = 24'($urandom); len = 16'($urandom);
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready low for 20 cycles after first valid
  task automatic run(input logic [23:0] a, input logic [15:0] n, input int mode, input bit dup);
    int base, falls0, to;
    base = done_cnt; falls0 = cs_falls;
    $display("txn addr=%06h len=%0d mode=%0d dup=%0d", a, n, mode, dup);
    push_expect(a, n);
    ready_mode = mode;
    if (mode == 0) rd_ready = 1'b1;
    if (mode == 2) rd_ready = 1'b0;
    pulse_start(a, n);
    @(negedge clk);
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    if (n == 0) begin
      chk("len0_done_early", {31'h0, done}, 32'h0);
      @(negedge clk);
      chk("len0_done", {31'h0, done}, 32'h1);
      chk("len0_busy", {31'h0, busy}, 32'h0);
    end
    if (mode == 2) begin
      to = 0;
      while (!rd_valid && to < 5000) begin @(negedge clk); to++; end
      if (to >= 5000) begin
        checks++; failures++;
        $display("FAIL first_valid_timeout actual=none required=rd_valid");
      end
      repeat (20) @(posedge clk);
      #1 rd_ready = 1'b1;
    end
    if (dup) begin
      repeat (30) @(posedge clk);
      #1 start = 1'b1; addr = 24'($urandom); len = 16'd5;
      @(posedge clk); #1 start = 1'b0;
    end
    to = 0;
    while (done_cnt == base && to < 8000) begin @(negedge clk); to++; end
    if (to >= 8000) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=none required=done");
    end
    repeat (5) @(negedge clk);
    ready_mode = 0;
    chk("done_count", 32'(done_cnt - base), 32'h1);
    chk("words_left", 32'(sb_q.size()), 32'h0);
    chk("cmd_left", 32'(exp_cmd.size()), 32'h0);
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("cs_idle", {31'h0, cs}, 32'h1);
    if (n == 0) chk("len0_no_cs", 32'(cs_falls - falls0), 32'h0);
    sb_q.delete();
    exp_cmd.delete();
  endtask

  initial begin
    int base, to;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    for (int i = 8; i < 256; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {31'h0, cs}, 32'h1);
    chk("rst_sclk", {31'h0, sclk}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_data", rd_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    run(24'h000000, 16'd1, 0, 1'b0);   // quad setup sequence
    run(24'h000000, 16'd2, 0, 1'b0);   // 0x44332211, 0x88776655
    run(24'h000000, 16'd2, 2, 1'b0);   // stall on first word
    run(24'h000000, 16'd0, 0, 1'b0);   // len 0
    run(24'h000010, 16'd3, 0, 1'b1);   // start while busy

    // reset while assembling the first of four words
    base = done_cnt;
    $display("txn addr=000000 len=4 reset-mid-data");
    push_expect(24'h000000, 16'd4);
    rd_ready = 1'b1;
    pulse_start(24'h000000, 16'd4);
    to = 0;
    while (!(op == 8'h6B && rcnt >= 32 + D + 3) && to < 5000) begin @(negedge clk); to++; end
    if (to >= 5000) begin
      checks++; failures++;
      $display("FAIL reach_data_timeout actual=none required=data_phase");
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_cs", {31'h0, cs}, 32'h1);
    chk("midrst_valid", {31'h0, rd_valid}, 32'h0);
    chk("midrst_sclk", {31'h0, sclk}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - base), 32'h0);
    sb_q.delete();
    exp_cmd.delete();
    run(24'h000004, 16'd1, 0, 1'b0);   // 0x88776655

    run(24'hFFFFFA, 16'd3, 1, 1'b0);   // wraps past 0xFFFFFF
    for (int t = 0; t < 6; t++) begin
      run(24'($urandom), 16'($urandom_range(1, 6)), int'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
